fetch_unit: RTL and testbench

Instruction-fetch front end for the pipelined RV32 core. It owns the fetch PC and issues in-order read requests on the instruction memory port. It buffers the returned words in a small queue and presents instr/PC/PC+4 to the decode/register stage over a valid/ready handshake. It yields the memory port to data accesses, and on a branch/jump redirect it flushes the queue and discards any in-flight responses.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_queue.sv | 47 ++++
 rtl/fetch_unit.sv | 93 +++++++++
 tb/tb_fetch_unit.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
package fetch_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int INSTR_W = 32;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fq_entry_t;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched instructions; flush beats push/pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  fq_entry_t                push_data,
  output logic [$clog2(QDEPTH):0]  count,
  output fq_entry_t                head
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;

  fq_entry_t      mem [QDEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           do_pop;

  assign do_pop = pop & (count != '0);
  // Empty queue presents zeros so the if_* bus never shows stale data.
  assign head   = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset | flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push & ~flush & ~reset) mem[wr_ptr] <= push_data;
  end

  // Slots are reserved at issue time, so a push can never meet a full queue.
  always_ff @(posedge clk) begin
    if (!reset && !flush) assert (!(push && count == CW'(QDEPTH)));
  end
endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the fetch PC, issues in-order imem reads with
// queue-slot credits, and drops in-flight responses after a redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          QDEPTH          = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        dmem_busy,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus_4
);
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]   fetch_pc, shadow_pc, target_pc, credit_used;
  logic [OW-1:0] outstanding, drop_cnt;
  logic [CW-1:0] q_count;
  fq_entry_t     q_head, q_in;
  logic          accept, rsp_ok, push, pop;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign target_pc = {redirect_pc[31:2], 2'b00};

  // Words already queued plus live (not-to-be-dropped) requests in flight.
  assign credit_used = 32'(q_count) + 32'(outstanding) - 32'(drop_cnt);

  assign imem_req_valid = ~reset & ~redirect_valid & ~dmem_busy
                        & (32'(outstanding) < 32'(MAX_OUTSTANDING))
                        & (credit_used < 32'(QDEPTH));
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid & imem_req_ready;

  assign rsp_ok = imem_rsp_valid & (outstanding != '0);
  assign push   = rsp_ok & (drop_cnt == '0) & ~redirect_valid;
  assign q_in   = '{instr: imem_rsp_data, pc: shadow_pc};

  assign if_valid     = ~reset & (q_count != '0);
  assign pop          = if_valid & if_ready;
  assign if_instr     = q_head.instr;
  assign if_pc        = q_head.pc;
  assign if_pc_plus_4 = (q_count != '0) ? pc_inc(q_head.pc) : 32'd0;

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .pop       (pop),
    .push_data (q_in),
    .count     (q_count),
    .head      (q_head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= {RESET_PC[31:2], 2'b00};
      shadow_pc   <= {RESET_PC[31:2], 2'b00};
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + OW'(accept) - OW'(rsp_ok);
      if (redirect_valid) begin
        fetch_pc  <= target_pc;
        shadow_pc <= target_pc;
        // Everything still in flight after this cycle belongs to the old path.
        drop_cnt  <= outstanding - OW'(rsp_ok);
      end else begin
        if (accept) fetch_pc  <= pc_inc(fetch_pc);
        if (push)   shadow_pc <= pc_inc(shadow_pc);
        if (rsp_ok && drop_cnt != '0) drop_cnt <= drop_cnt - OW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (!(imem_rsp_valid && outstanding == '0));
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Cycle-level check of fetch_unit against a queue-based model of the fetch stream.
module tb_fetch_unit;
  localparam int          QD  = 4;
  localparam int          MO  = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, redirect_valid, dmem_busy, imem_req_ready, imem_rsp_valid, if_ready;
  logic [31:0] redirect_pc, imem_rsp_data;
  logic        imem_req_valid, if_valid;
  logic [31:0] imem_req_addr, if_instr, if_pc, if_pc_plus_4;

  always #5 clk = ~clk;

  fetch_unit #(.QDEPTH(QD), .MAX_OUTSTANDING(MO), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dmem_busy(dmem_busy), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .if_pc_plus_4(if_pc_plus_4)
  );

  typedef struct { logic [31:0] addr; int due; bit killed; } req_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;

  req_t        fl[$];   // accepted requests, oldest first; killed = belongs to an old path
  ent_t        mq[$];   // instructions the decode stage should see, in order
  logic [31:0] fpc;
  int          cyc = 0, last_due = -1;
  int          checks = 0, failures = 0;
  int          p_rdy = 100, p_ifr = 100, p_busy = 0, lat_lo = 1, lat_hi = 1;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic step(input bit rst, input bit redir, input logic [31:0] rpc);
    bit   exp_v, exp_if, do_pop;
    int   live, d;
    req_t r;
    @(negedge clk);
    reset          = rst;
    redirect_valid = redir;
    redirect_pc    = rpc;
    dmem_busy      = ($urandom_range(99) < p_busy);
    imem_req_ready = ($urandom_range(99) < p_rdy);
    if_ready       = ($urandom_range(99) < p_ifr);
    imem_rsp_valid = !rst && fl.size() > 0 && fl[0].due <= cyc;
    imem_rsp_data  = imem_rsp_valid ? memw(fl[0].addr) : $urandom;
    #1;
    live = 0;
    foreach (fl[i]) if (!fl[i].killed) live++;
    exp_v  = !rst && !redir && !dmem_busy && fl.size() < MO && (mq.size() + live) < QD;
    exp_if = !rst && mq.size() > 0;

    checks++;
    assert (imem_req_valid === exp_v) else begin
      failures++; $error("FAIL req_valid cyc=%0d got=%0b exp=%0b", cyc, imem_req_valid, exp_v);
    end
    if (exp_v) begin
      checks++;
      assert (imem_req_addr === fpc) else begin
        failures++; $error("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, fpc);
      end
    end
    checks++;
    assert (if_valid === exp_if) else begin
      failures++; $error("FAIL if_valid cyc=%0d got=%0b exp=%0b", cyc, if_valid, exp_if);
    end
    if (!rst) begin
      checks++;
      if (mq.size() > 0) begin
        assert ({if_instr, if_pc, if_pc_plus_4} === {mq[0].instr, mq[0].pc, mq[0].pc + 32'd4}) else begin
          failures++;
          $error("FAIL if_head cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc, if_instr, if_pc,
                 if_pc_plus_4, mq[0].instr, mq[0].pc, mq[0].pc + 32'd4);
        end
      end else begin
        assert ({if_instr, if_pc, if_pc_plus_4} === 96'd0) else begin
          failures++;
          $error("FAIL if_empty cyc=%0d got=%h/%h/%h exp=0/0/0", cyc, if_instr, if_pc, if_pc_plus_4);
        end
      end
    end

    if (rst) begin
      fl.delete(); mq.delete(); fpc = RPC; last_due = cyc;
    end else begin
      do_pop = exp_if && if_ready && !redir;
      if (do_pop) void'(mq.pop_front());
      if (imem_rsp_valid) begin
        r = fl.pop_front();
        if (!r.killed && !redir) mq.push_back('{memw(r.addr), r.addr});
      end
      if (redir) begin
        mq.delete();
        foreach (fl[i]) fl[i].killed = 1'b1;
        fpc = {rpc[31:2], 2'b00};
      end else if (exp_v && imem_req_ready) begin
        d = cyc + $urandom_range(lat_hi, lat_lo);
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        fl.push_back('{fpc, d, 1'b0});
        fpc = fpc + 32'd4;
      end
    end
    cyc++;
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; dmem_busy = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; if_ready = 1'b0;
    fpc = RPC;
    step(1, 0, 0); step(1, 0, 0);

    // Streaming with single-cycle memory, then a 3-cycle dmem_busy window.
    repeat (20) step(0, 0, 0);
    p_busy = 100; repeat (3) step(0, 0, 0);
    p_busy = 0;   repeat (10) step(0, 0, 0);

    // Decode stalled: issue must stop at QDEPTH words, then resume cleanly.
    step(1, 0, 0);
    p_ifr = 0;   repeat (12) step(0, 0, 0);
    p_ifr = 100; repeat (12) step(0, 0, 0);

    // 3-cycle memory, two in flight, redirect to an unaligned target.
    step(1, 0, 0);
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 20 && fl.size() < 2; i++) step(0, 0, 0);
    checks++;
    assert (fl.size() == 2) else begin
      failures++; $error("FAIL two_outstanding got=%0d exp=2", fl.size());
    end
    step(0, 1, 32'h0000_0103);
    repeat (15) step(0, 0, 0);

    // Redirect while a response lands and the head is being consumed.
    lat_lo = 1; lat_hi = 1;
    repeat (8) step(0, 0, 0);
    step(0, 1, 32'h0000_0200);
    step(0, 1, 32'h0000_0300);
    repeat (10) step(0, 0, 0);

    // Address wrap at the top of memory.
    step(0, 1, 32'hFFFF_FFFC);
    repeat (12) step(0, 0, 0);

    // Randomized traffic with mixed latency, stalls, redirects and resets.
    lat_lo = 1; lat_hi = 4;
    for (int n = 0; n < 1500; n++) begin
      if (n % 100 == 0) begin
        p_rdy  = $urandom_range(100, 30);
        p_ifr  = $urandom_range(100, 20);
        p_busy = $urandom_range(40);
      end
      step($urandom_range(199) == 0, $urandom_range(15) == 0, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
